// File: rtl/mem_stage_unit_pkg.sv
// Shared definitions for the memory stage: state encoding and default widths.
package mem_stage_unit_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int RA_W_DEF  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;
endpackage

// File: rtl/mem_stage_unit_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface mem_stage_unit_if
  import mem_stage_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             dmem_req;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic             dmem_ack;
  logic [WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_unit_flop_mw.sv
// M/W pipeline register. A bubble clears the W controls but keeps the datapath
// values; read data is captured separately so stores leave it untouched.
module mem_stage_unit_flop_mw
  import mem_stage_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bubble,
  input  logic             rd_en,
  input  logic             PCSrcM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [WIDTH-1:0] rdata,
  output logic             PCSrcW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [RA_W-1:0]  WA3W
);
  logic             pcsrc_q, pcsrc_d;
  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [RA_W-1:0]  wa3_q, wa3_d;

  always_comb begin
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    readdata_d = readdata_q;
    aluout_d   = aluout_q;
    wa3_d      = wa3_q;
    if (en) begin
      if (bubble) begin
        pcsrc_d    = 1'b0;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
      end else begin
        pcsrc_d    = PCSrcM;
        regwrite_d = RegWriteM;
        memtoreg_d = MemtoRegM;
        aluout_d   = ALUResultM;
        wa3_d      = WA3M;
      end
    end
    if (rd_en) readdata_d = rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      readdata_q <= '0;
      aluout_q   <= '0;
      wa3_q      <= '0;
    end else begin
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      readdata_q <= readdata_d;
      aluout_q   <= aluout_d;
      wa3_q      <= wa3_d;
    end
  end

  assign PCSrcW    = pcsrc_q;
  assign RegWriteW = regwrite_q;
  assign MemtoRegW = memtoreg_q;
  assign ReadDataW = readdata_q;
  assign ALUOutW   = aluout_q;
  assign WA3W      = wa3_q;
endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: issues one data-memory access per load/store, stalls upstream
// until the ack, and feeds the M/W register (bubbling W while waiting).
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCSrcM,
  input  logic                 RegWriteM,
  input  logic                 MemtoRegM,
  input  logic                 MemWriteM,
  input  logic [WIDTH-1:0]     ALUResultM,
  input  logic [WIDTH-1:0]     WriteDataM,
  input  logic [RA_W-1:0]      WA3M,
  mem_stage_unit_if.master     dmem,
  output logic                 StallM,
  output logic                 PCSrcW,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [WIDTH-1:0]     ReadDataW,
  output logic [WIDTH-1:0]     ALUOutW,
  output logic [RA_W-1:0]      WA3W
);
  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             memop, stall, mw_en, mw_bubble, rd_en;

  always_comb begin
    memop     = MemtoRegM | MemWriteM;
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    stall     = 1'b0;
    mw_en     = 1'b0;
    mw_bubble = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        mw_en = 1'b1;
        if (memop) begin
          stall     = 1'b1;
          mw_bubble = 1'b1;
          state_d   = REQ;
          req_d     = 1'b1;
          we_d      = MemWriteM;
          addr_d    = ALUResultM;
          wdata_d   = WriteDataM;
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          mw_en   = 1'b1;
          rd_en   = ~we_q;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Stall is combinational, so mask it while reset holds the stage idle.
  assign StallM          = stall & reset;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  mem_stage_unit_flop_mw #(.WIDTH(WIDTH), .RA_W(RA_W)) u_flop_mw (
    .clk        (clk),
    .reset      (reset),
    .en         (mw_en),
    .bubble     (mw_bubble),
    .rd_en      (rd_en),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .ALUResultM (ALUResultM),
    .WA3M       (WA3M),
    .rdata      (dmem.dmem_rdata),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WA3W       (WA3W)
  );
endmodule

// File: tb/tb_mem_stage_unit.sv
// Transaction-level bench for mem_stage_unit: each instruction is run through
// its expected cycle sequence while a small model tracks the W-stage results.
module tb_mem_stage_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WA3M;
  logic        StallM, PCSrcW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [3:0]  WA3W;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd = 32'h0;

  mem_stage_unit_if #(.WIDTH(32)) dmem_bus ();

  mem_stage_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .WA3M       (WA3M),
    .dmem       (dmem_bus.master),
    .StallM     (StallM),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WA3W       (WA3W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One instruction through M: issue cycle, nwait stalled REQ cycles, then ack.
  task automatic run_op(input logic pc, input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa,
                        input int nwait, input logic [31:0] rdat, input logic stray_ack);
    logic is_mem;
    is_mem = m2r | mw;
    @(negedge clk);
    PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; WA3M = wa;
    dmem_bus.dmem_ack   = is_mem ? 1'b0 : stray_ack;
    dmem_bus.dmem_rdata = $urandom;
    #1;
    check("stall_issue", StallM, is_mem);
    check("req_before_issue", dmem_bus.dmem_req, 0);
    @(posedge clk); #1;
    if (!is_mem) begin
      check("req_alu", dmem_bus.dmem_req, 0);
      check("pcsrc_alu", PCSrcW, pc);
      check("regwrite_alu", RegWriteW, rw);
      check("memtoreg_alu", MemtoRegW, 1'b0);
      check("aluout_alu", ALUOutW, alu);
      check("wa3_alu", WA3W, wa);
      check("readdata_hold", ReadDataW, exp_rd);
    end else begin
      check("req_issued", dmem_bus.dmem_req, 1);
      check("we_issued", dmem_bus.dmem_we, mw);
      check("addr_issued", dmem_bus.dmem_addr, alu);
      check("wdata_issued", dmem_bus.dmem_wdata, wd);
      check("bubble_ctrl", {PCSrcW, RegWriteW, MemtoRegW}, 3'b000);
      for (int k = 0; k <= nwait; k++) begin
        @(negedge clk);
        dmem_bus.dmem_ack   = (k == nwait);
        dmem_bus.dmem_rdata = (k == nwait) ? rdat : $urandom;
        #1;
        check("stall_req", StallM, (k != nwait));
        check("req_held", dmem_bus.dmem_req, 1);
        check("we_held", dmem_bus.dmem_we, mw);
        check("addr_held", dmem_bus.dmem_addr, alu);
        check("wdata_held", dmem_bus.dmem_wdata, wd);
        @(posedge clk); #1;
        if (k != nwait) begin
          check("bubble_wait", {PCSrcW, RegWriteW, MemtoRegW}, 3'b000);
          check("readdata_wait", ReadDataW, exp_rd);
        end
      end
      if (!mw) exp_rd = rdat;
      check("req_dropped", dmem_bus.dmem_req, 0);
      check("pcsrc_mem", PCSrcW, pc);
      check("regwrite_mem", RegWriteW, rw);
      check("memtoreg_mem", MemtoRegW, m2r);
      check("aluout_mem", ALUOutW, alu);
      check("wa3_mem", WA3W, wa);
      check("readdata_mem", ReadDataW, exp_rd);
    end
    $display("op pc=%0d rw=%0d ld=%0d st=%0d addr=%08h wa=%0d wait=%0d rd=%08h",
             pc, rw, m2r, mw, alu, wa, is_mem ? nwait : 0, ReadDataW);
  endtask

  initial begin
    reset = 1'b0;
    PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUResultM = 0; WriteDataM = 0; WA3M = 0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_req", dmem_bus.dmem_req, 0);
    check("rst_stall", StallM, 0);
    check("rst_w", {PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W}, 0);
    reset = 1'b1;

    // directed cases
    run_op(0, 1, 0, 0, 32'h10, 32'h0, 4'd3, 0, 32'h0, 0);
    run_op(0, 1, 1, 0, 32'h100, 32'h0, 4'd5, 0, 32'hDEADBEEF, 0);
    run_op(0, 0, 0, 1, 32'h200, 32'h1234, 4'd0, 3, 32'h0BAD0BAD, 0);
    run_op(0, 1, 1, 0, 32'h104, 32'h0, 4'd6, 0, 32'hCAFEF00D, 0);
    run_op(0, 0, 0, 1, 32'h204, 32'h5678, 4'd0, 0, 32'h11111111, 0);
    run_op(0, 1, 1, 1, 32'h300, 32'h9ABC, 4'd7, 1, 32'h22222222, 0);
    run_op(1, 0, 0, 0, 32'h44, 32'h0, 4'd9, 0, 32'h0, 1);

    // reset while a load is outstanding
    @(negedge clk);
    MemtoRegM = 1; RegWriteM = 1; ALUResultM = 32'h400; WA3M = 4'd2;
    @(posedge clk); #1;
    check("rstmid_req_before", dmem_bus.dmem_req, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstmid_req", dmem_bus.dmem_req, 0);
    check("rstmid_stall", StallM, 0);
    check("rstmid_w", {PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W}, 0);
    exp_rd = 32'h0;
    @(negedge clk);
    PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUResultM = 0; WA3M = 0;
    reset = 1'b1;
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("late_ack_req", dmem_bus.dmem_req, 0);
    check("late_ack_rd", ReadDataW, exp_rd);
    check("late_ack_stall", StallM, 0);

    // randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (kind == 1 || kind == 3), (kind == 2 || kind == 3),
             $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
